// File: rtl/mano_pkg.sv
// Shared constants for the basic-computer control unit: bus selector codes,
// ALU operations, opcodes, register-reference bit positions and timing steps.
package mano_pkg;

  localparam int unsigned SC_W  = 4;
  localparam int unsigned AW    = 12;
  localparam int unsigned BUS_W = 3;

  // Bus selector codes
  localparam logic [BUS_W-1:0] BUS_MEM  = 3'd0;
  localparam logic [BUS_W-1:0] BUS_AR   = 3'd1;
  localparam logic [BUS_W-1:0] BUS_PC   = 3'd2;
  localparam logic [BUS_W-1:0] BUS_DR   = 3'd3;
  localparam logic [BUS_W-1:0] BUS_AC   = 3'd4;
  localparam logic [BUS_W-1:0] BUS_IR   = 3'd5;
  localparam logic [BUS_W-1:0] BUS_TR   = 3'd6;
  localparam logic [BUS_W-1:0] BUS_NONE = 3'd7;

  typedef enum logic [2:0] {
    ALU_AND     = 3'd0,
    ALU_ADD     = 3'd1,
    ALU_PASS_DR = 3'd2,
    ALU_CMA     = 3'd3,
    ALU_CIR     = 3'd4,
    ALU_CIL     = 3'd5
  } alu_op_e;

  // Opcode field IR[14:12]
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_IO  = 3'd7;

  // Register-reference bit positions within IR[11:0]
  localparam int unsigned RR_CLA = 11;
  localparam int unsigned RR_CLE = 10;
  localparam int unsigned RR_CMA = 9;
  localparam int unsigned RR_CME = 8;
  localparam int unsigned RR_CIR = 7;
  localparam int unsigned RR_CIL = 6;
  localparam int unsigned RR_INC = 5;
  localparam int unsigned RR_SPA = 4;
  localparam int unsigned RR_SNA = 3;
  localparam int unsigned RR_SZA = 2;
  localparam int unsigned RR_SZE = 1;
  localparam int unsigned RR_HLT = 0;

  // Timing steps
  localparam logic [SC_W-1:0] T0 = 4'd0;
  localparam logic [SC_W-1:0] T1 = 4'd1;
  localparam logic [SC_W-1:0] T2 = 4'd2;
  localparam logic [SC_W-1:0] T3 = 4'd3;
  localparam logic [SC_W-1:0] T4 = 4'd4;
  localparam logic [SC_W-1:0] T5 = 4'd5;
  localparam logic [SC_W-1:0] T6 = 4'd6;

endpackage

// File: rtl/mano_seq_counter.sv
// Sequence counter: W-bit step counter, clear has priority over increment.
// Ports: clk, rst (async, active-high), inc, clr, count.
module mano_seq_counter
  import mano_pkg::*;
#(
  parameter int unsigned W = SC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mano_control_unit.sv
// Timing and control sequencer for the 16-bit basic computer. Decodes the
// run flag S, the step counter SC, IR and the AC/E/DR flags into the bus
// selector, register strobes, memory strobes and ALU op for each cycle.
// Ports: clk, rst (async, active-high), start, ir, ac_msb, ac_zero, dr_zero,
//        e_flag in; bus_sel, register/memory/E strobes, alu_op, running, sc out.
module mano_control_unit
  import mano_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      ir,
  input  logic             ac_msb,
  input  logic             ac_zero,
  input  logic             dr_zero,
  input  logic             e_flag,
  output logic [BUS_W-1:0] bus_sel,
  output logic             ar_ld,
  output logic             ar_inc,
  output logic             ar_clr,
  output logic             pc_ld,
  output logic             pc_inc,
  output logic             pc_clr,
  output logic             dr_ld,
  output logic             dr_inc,
  output logic             ac_ld,
  output logic             ac_inc,
  output logic             ac_clr,
  output logic             ir_ld,
  output logic             tr_ld,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [2:0]       alu_op,
  output logic             e_clr,
  output logic             e_cmp,
  output logic             running,
  output logic [SC_W-1:0]  sc
);

  logic            run_d;
  logic            run_q;
  logic            sc_inc;
  logic            sc_clr;
  logic [SC_W-1:0] sc_q;
  logic [2:0]      d_op;
  logic            ind;
  logic [AW-1:0]   b;
  logic            skip;
  alu_op_e         alu_sel;

  assign d_op = ir[14:12];
  assign ind  = ir[15];
  assign b    = ir[AW-1:0];

  // Any enabled skip condition folds into one PC increment
  assign skip = (b[RR_SPA] & ~ac_msb) | (b[RR_SNA] & ac_msb) |
                (b[RR_SZA] & ac_zero) | (b[RR_SZE] & ~e_flag);

  mano_seq_counter #(.W(SC_W)) u_sc (
    .clk   (clk),
    .rst   (rst),
    .inc   (sc_inc),
    .clr   (sc_clr),
    .count (sc_q)
  );

  // Run flip-flop S
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
    end else begin
      run_q <= run_d;
    end
  end

  // Step decode: next S, counter control and all per-cycle strobes
  always_comb begin
    run_d   = run_q | start;
    sc_inc  = run_q;
    sc_clr  = 1'b0;
    bus_sel = BUS_NONE;
    ar_ld   = 1'b0;
    ar_inc  = 1'b0;
    ar_clr  = 1'b0;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    pc_clr  = 1'b0;
    dr_ld   = 1'b0;
    dr_inc  = 1'b0;
    ac_ld   = 1'b0;
    ac_inc  = 1'b0;
    ac_clr  = 1'b0;
    ir_ld   = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    e_clr   = 1'b0;
    e_cmp   = 1'b0;
    alu_sel = ALU_AND;

    if (run_q) begin
      case (sc_q)
        T0: begin
          bus_sel = BUS_PC;
          ar_ld   = 1'b1;
        end
        T1: begin
          bus_sel = BUS_MEM;
          mem_rd  = 1'b1;
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
        end
        T2: begin
          bus_sel = BUS_IR;
          ar_ld   = 1'b1;
        end
        T3: begin
          if (d_op == OP_IO) begin
            sc_clr = 1'b1;
            if (!ind) begin
              // AC operations are mutually exclusive; highest priority wins
              if (b[RR_CLA]) begin
                ac_clr = 1'b1;
              end else if (b[RR_CMA]) begin
                ac_ld   = 1'b1;
                alu_sel = ALU_CMA;
              end else if (b[RR_CIR]) begin
                ac_ld   = 1'b1;
                alu_sel = ALU_CIR;
              end else if (b[RR_CIL]) begin
                ac_ld   = 1'b1;
                alu_sel = ALU_CIL;
              end else if (b[RR_INC]) begin
                ac_inc = 1'b1;
              end
              if (b[RR_CLE]) begin
                e_clr = 1'b1;
              end else if (b[RR_CME]) begin
                e_cmp = 1'b1;
              end
              pc_inc = skip;
              if (b[RR_HLT]) begin
                run_d = 1'b0;
              end
            end
          end else if (ind) begin
            bus_sel = BUS_MEM;
            mem_rd  = 1'b1;
            ar_ld   = 1'b1;
          end
        end
        T4: begin
          case (d_op)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              bus_sel = BUS_MEM;
              mem_rd  = 1'b1;
              dr_ld   = 1'b1;
            end
            OP_STA: begin
              bus_sel = BUS_AC;
              mem_wr  = 1'b1;
              sc_clr  = 1'b1;
            end
            OP_BUN: begin
              bus_sel = BUS_AR;
              pc_ld   = 1'b1;
              sc_clr  = 1'b1;
            end
            OP_BSA: begin
              bus_sel = BUS_PC;
              mem_wr  = 1'b1;
              ar_inc  = 1'b1;
            end
            default: sc_clr = 1'b1;
          endcase
        end
        T5: begin
          case (d_op)
            OP_AND: begin
              ac_ld   = 1'b1;
              alu_sel = ALU_AND;
              sc_clr  = 1'b1;
            end
            OP_ADD: begin
              ac_ld   = 1'b1;
              alu_sel = ALU_ADD;
              sc_clr  = 1'b1;
            end
            OP_LDA: begin
              ac_ld   = 1'b1;
              alu_sel = ALU_PASS_DR;
              sc_clr  = 1'b1;
            end
            OP_BSA: begin
              bus_sel = BUS_AR;
              pc_ld   = 1'b1;
              sc_clr  = 1'b1;
            end
            OP_ISZ: dr_inc = 1'b1;
            default: sc_clr = 1'b1;
          endcase
        end
        T6: begin
          sc_clr = 1'b1;
          if (d_op == OP_ISZ) begin
            bus_sel = BUS_DR;
            mem_wr  = 1'b1;
            pc_inc  = dr_zero;
          end
        end
        // Unreachable steps recover to T0 without side effects
        default: sc_clr = 1'b1;
      endcase
    end
  end

  assign alu_op  = alu_sel;
  assign tr_ld   = 1'b0;
  assign running = run_q;
  assign sc      = sc_q;

endmodule
